// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state codes, default sizing and
// the word-index width helper.
package dmem_pkg;

  localparam int unsigned DefDepth      = 256;
  localparam int unsigned DefWaitCycles = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide backing store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = idx_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed number of wait states, request
// error decode and a valid/ready response handshake.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] readdata,
  output logic        resp_err
);

  localparam int unsigned IW = idx_width(DEPTH);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rd_q, wr_q, err_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;

  logic          accept, req_err;
  logic [IW-1:0] req_idx;
  logic          we;
  logic [IW-1:0] waddr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign req_idx   = address[IW+1:2];
  assign req_err   = (memread == memwrite) | (address[1:0] != 2'b00) |
                     ({2'b00, address[31:2]} >= DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The store lands on the edge that enters RESP; with no wait states that is the accepting edge.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      we    = accept & memwrite & ~req_err;
      waddr = req_idx;
      wdata = writedata;
    end else begin
      we    = (state_q == WAIT) & (cnt_q == 4'd0) & wr_q & ~err_q;
      waddr = idx_q;
      wdata = wdata_q;
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rd_q    <= memread;
        wr_q    <= memwrite;
        err_q   <= req_err;
        idx_q   <= req_idx;
        wdata_q <= writedata;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (IW)
  ) u_array (
    .clk_i   (clock),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (idx_q),
    .rdata_o (rdata)
  );

  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign readdata   = (resp_valid & rd_q & ~err_q) ? rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written handshake and
// reset sequences, then randomized traffic against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WAITC = 2;

  logic        clock = 1'b0;
  logic        Reset;
  logic        req_valid, req_ready, memread, memwrite;
  logic [31:0] address, writedata, readdata;
  logic        resp_valid, resp_ready, resp_err;

  int passed = 0;
  int total  = 0;

  logic [31:0] model_mem [DEPTH];

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  dmem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clock      (clock),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .memread    (memread),
    .memwrite   (memwrite),
    .address    (address),
    .writedata  (writedata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .readdata   (readdata),
    .resp_err   (resp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = v;
    memread   = rd;
    memwrite  = wr;
    address   = a;
    writedata = d;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check({name, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic txn(input string nm, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input int stall, input logic exp_err,
                     input logic [31:0] exp_data);
    int lat;
    @(negedge clock);
    drive(1'b1, rd, wr, a, d);
    wait_ready(nm);
    @(posedge clock);
    @(negedge clock);
    // Garbage request while busy must be ignored.
    drive(1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom);
    wait_resp(lat);
    req_valid = 1'b0;
    check({nm, "_lat"}, 32'(lat), 32'(WAITC + 1));
    check({nm, "_err"}, 32'(resp_err), 32'(exp_err));
    check({nm, "_data"}, readdata, exp_data);
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      check({nm, "_hold"}, {28'd0, resp_valid, req_ready, resp_err, 1'b0}, {28'd0, 2'b10, exp_err, 1'b0});
      check({nm, "_hold_data"}, readdata, exp_data);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check({nm, "_idle"}, {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  task automatic model_txn(input string nm, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d, input int stall);
    logic        err;
    logic [31:0] exp;
    err = (rd == wr) || (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    exp = 32'd0;
    if (!err && rd) exp = model_mem[a >> 2];
    if (!err && wr) model_mem[a >> 2] = d;
    txn(nm, rd, wr, a, d, stall, err, exp);
  endtask

  initial begin
    int lat;
    Reset      = 1'b0;
    resp_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("reset_outputs", {29'd0, resp_valid, resp_err, req_ready}, 32'd1);
    check("reset_readdata", readdata, 32'd0);
    repeat (3) @(negedge clock);
    Reset = 1'b1;
    @(negedge clock);
    check("post_reset_ready", 32'(req_ready), 32'd1);

    vecs.push_back('{"st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'd0});
    vecs.push_back('{"ld10", 1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{"st12_mis", 1'b0, 1'b1, 32'h12, 32'h0000CAFE, 0, 1'b1, 32'd0});
    vecs.push_back('{"ld10_b", 1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{"ld400_oor", 1'b1, 1'b0, 32'h400, 32'h0, 0, 1'b1, 32'd0});
    vecs.push_back('{"both10", 1'b1, 1'b1, 32'h10, 32'h11111111, 0, 1'b1, 32'd0});
    vecs.push_back('{"ld10_c", 1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{"none10", 1'b0, 1'b0, 32'h10, 32'h22222222, 0, 1'b1, 32'd0});
    vecs.push_back('{"st3fc", 1'b0, 1'b1, 32'h3FC, 32'h0BADF00D, 0, 1'b0, 32'd0});
    vecs.push_back('{"ld3fc", 1'b1, 1'b0, 32'h3FC, 32'h0, 0, 1'b0, 32'h0BADF00D});
    vecs.push_back('{"ld11_mis", 1'b1, 1'b0, 32'h11, 32'h0, 0, 1'b1, 32'd0});
    vecs.push_back('{"ld_high", 1'b1, 1'b0, 32'hFFFFFFF0, 32'h0, 0, 1'b1, 32'd0});
    vecs.push_back('{"ld10_stall", 1'b1, 1'b0, 32'h10, 32'h0, 5, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{"err_stall", 1'b0, 1'b1, 32'h401, 32'h0, 3, 1'b1, 32'd0});
    foreach (vecs[i]) begin
      txn(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].stall,
          vecs[i].exp_err, vecs[i].exp_data);
    end

    // Back-to-back: a request held during the response handshake waits one idle cycle.
    @(negedge clock);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    wait_ready("b2b_first");
    @(posedge clock);
    @(negedge clock);
    drive(1'b1, 1'b1, 1'b0, 32'h3FC, 32'h0);
    wait_resp(lat);
    check("b2b_first_data", readdata, 32'hDEADBEEF);
    check("b2b_busy", 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check("b2b_no_same_edge", {30'd0, resp_valid, req_ready}, 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
    check("b2b_accepted", 32'(req_ready), 32'd0);
    wait_resp(lat);
    check("b2b_second_lat", 32'(lat), 32'(WAITC + 1));
    check("b2b_second_data", readdata, 32'h0BADF00D);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;

    // Reset during WAIT aborts a pending store.
    txn("pre20", 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 0, 1'b0, 32'd0);
    @(negedge clock);
    drive(1'b1, 1'b0, 1'b1, 32'h20, 32'h12345678);
    wait_ready("rst_wait");
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    #2 Reset = 1'b0;
    #1;
    check("rst_wait_outputs", {29'd0, resp_valid, resp_err, req_ready}, 32'd1);
    check("rst_wait_readdata", readdata, 32'd0);
    repeat (2) @(negedge clock);
    Reset = 1'b1;
    txn("ld20_after_rst", 1'b1, 1'b0, 32'h20, 32'h0, 0, 1'b0, 32'hA5A5A5A5);

    // Reset during a stalled load response clears outputs asynchronously.
    @(negedge clock);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    wait_ready("rst_resp");
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    wait_resp(lat);
    check("rst_resp_before", readdata, 32'hDEADBEEF);
    #2 Reset = 1'b0;
    #1;
    check("rst_resp_outputs", {29'd0, resp_valid, resp_err, req_ready}, 32'd1);
    check("rst_resp_readdata", readdata, 32'd0);
    @(negedge clock);
    Reset = 1'b1;
    txn("ld10_after_rst", 1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'hDEADBEEF);

    // Randomized traffic confined to a preloaded window plus error cases.
    for (int i = 64; i < 96; i++) begin
      model_txn("preload", 1'b0, 1'b1, 32'(i) << 2, $urandom, 0);
    end
    for (int n = 0; n < 80; n++) begin
      int unsigned k, idx;
      logic        rd;
      logic [31:0] a;
      k   = $urandom_range(0, 9);
      idx = $urandom_range(64, 95);
      rd  = 1'($urandom);
      a   = 32'(idx) << 2;
      case (k)
        6:       model_txn("rnd_mis", rd, ~rd, a | 32'($urandom_range(1, 3)), $urandom, 0);
        7:       model_txn("rnd_oor", rd, ~rd, 32'h400 + (32'($urandom_range(0, 4000)) << 2),
                           $urandom, 0);
        8:       model_txn("rnd_both", 1'b1, 1'b1, a, $urandom, 0);
        9:       model_txn("rnd_none", 1'b0, 1'b0, a, $urandom, 0);
        default: model_txn("rnd_ok", rd, ~rd, a, $urandom, $urandom_range(0, 2));
      endcase
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DEPTH, 256, number of 32-bit words in the backing array (power of two).
REQ-002 Parameter: WAIT_CYCLES, 2, wait states inserted between request acceptance and response (0..15).
REQ-003 Port: clock  input  1  single clock; all state changes on rising edge.
REQ-004 Port: Reset  input  1  asynchronous, active-low reset.
REQ-005 Port: req_valid  input  1  CPU request present.
REQ-006 Port: req_ready  output  1  responder can accept a request.
REQ-007 Port: memread  input  1  request is a load.
REQ-008 Port: memwrite  input  1  request is a store.
REQ-009 Port: address  input  32  byte address.
REQ-010 Port: writedata  input  32  store data.
REQ-011 Port: resp_valid  output  1  response present.
REQ-012 Port: resp_ready  input  1  CPU consumes response.
REQ-013 Port: readdata  output  32  load data; 0 for stores and errors.
REQ-014 Port: resp_err  output  1  request rejected; no array side effect.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; memread, memwrite, address and writedata SHALL be registered at that edge.
REQ-018 On acceptance: WAIT_CYCLES>0 -> WAIT with counter loaded to WAIT_CYCLES-1; WAIT_CYCLES=0 -> RESP.
REQ-019 In WAIT the counter SHALL decrement each cycle; WAIT -> RESP on the edge where the counter is 0.
REQ-020 resp_valid SHALL first assert WAIT_CYCLES+1 cycles after the accepting edge.
REQ-021 Error SHALL be flagged when memread equals memwrite (both or neither), address[1:0] != 0, or address[31:2] >= DEPTH.
REQ-022 A valid store SHALL write the array on the edge entering RESP, exactly once per accepted request.
REQ-023 A valid load SHALL present array[address[31:2]] on readdata for the whole RESP state.
REQ-024 In RESP, resp_valid=1; readdata and resp_err SHALL hold stable until resp_ready=1 is sampled; then -> IDLE.
REQ-025 resp_valid and resp_ready both 1 with req_valid=1 SHALL NOT accept a new request on the same edge; the new request is accepted no earlier than the following edge (one idle cycle minimum).
REQ-026 Request inputs SHALL be ignored outside IDLE.
REQ-027 resp_valid, readdata and resp_err SHALL be 0 outside RESP.

Reset
REQ-028 Reset=0 SHALL force, immediately and asynchronously: state IDLE, counter 0, req_ready=1 after release, resp_valid=0, readdata=0, resp_err=0.
REQ-029 Reset during WAIT SHALL abort the request; a pending store SHALL NOT be written.
REQ-030 Array contents SHALL NOT be cleared by reset.

Structure
REQ-031 Shared package dmem_pkg SHALL hold the state enumeration, default DEPTH and WAIT_CYCLES, and the word-index width function.
REQ-032 Storage SHALL be a sub-module dmem_array (one synchronous write port, one combinational read port, DEPTH words x 32 bits); FSM, counter and error decode stay in dmem_responder.

Verification
REQ-033 Reset release, store addr 0x10 data 0xDEADBEEF, resp_ready=1 -> resp_valid on 3rd edge after acceptance, resp_err=0, readdata=0.
REQ-034 Load addr 0x10 after REQ-033 -> readdata=0xDEADBEEF, resp_err=0, latency 3 cycles.
REQ-035 Store addr 0x12 (misaligned), then load 0x10 -> first response resp_err=1; load returns 0xDEADBEEF unchanged.
REQ-036 Load addr 0x400 with DEPTH=256 -> resp_err=1, readdata=0; memread=memwrite=1 -> resp_err=1, no write.
REQ-037 Load accepted, resp_ready held 0 for 5 cycles -> resp_valid, readdata stable for all 5; req_ready=0; back-to-back request accepted only after the handshake.
REQ-038 Store 0x20 data 0x12345678, Reset pulsed low during WAIT, then load 0x20 -> outputs 0 immediately on Reset; load returns prior contents, not 0x12345678.
